// File: rtl/cellrv32_gptmr_mc.sv
// Multi-channel general-purpose timer with a 64-byte memory-mapped register window.
// Each channel counts prescaler ticks up to a threshold, in single-shot or continuous mode.
module cellrv32_gptmr_mc #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'hFFFFF000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] addr_i,
  input  logic        rden_i,
  input  logic        wren_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        clkgen_en_o,
  input  logic [7:0]  clkgen_i,
  output logic        irq_o
);

  localparam logic [1:0] RegCtrl  = 2'd0;
  localparam logic [1:0] RegThres = 2'd1;
  localparam logic [1:0] RegCount = 2'd2;
  localparam logic [1:0] RegStat  = 2'd3;

  logic       acc, rd, wr;
  logic [1:0] ch_sel, reg_sel;
  logic       unused_bits;

  assign acc     = (addr_i[31:6] == BASE_ADDR[31:6]);
  assign rd      = acc & rden_i;
  assign wr      = acc & wren_i;
  assign ch_sel  = addr_i[5:4];
  assign reg_sel = addr_i[3:2];
  // Byte offset and upper write-data bits are don't-care for some configurations.
  assign unused_bits = ^{addr_i[1:0], data_i};

  logic [NUM_CH-1:0] en_q, en_d, mode_q, mode_d, irqen_q, irqen_d;
  logic [NUM_CH-1:0] done_q, done_d, pend_q, pend_d, tick_q, tick_d;
  logic [2:0]        prsc_q  [NUM_CH];
  logic [2:0]        prsc_d  [NUM_CH];
  logic [CNT_W-1:0]  thres_q [NUM_CH];
  logic [CNT_W-1:0]  thres_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];

  logic [NUM_CH-1:0] wr_ctrl, wr_thres, wr_cnt, wr_stat, match, evt;

  logic [31:0] rdata, data_q;
  logic        ack_q, irq_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_ctrl[i]  = wr && (ch_sel == 2'(i)) && (reg_sel == RegCtrl);
    assign wr_thres[i] = wr && (ch_sel == 2'(i)) && (reg_sel == RegThres);
    assign wr_cnt[i]   = wr && (ch_sel == 2'(i)) && (reg_sel == RegCount);
    assign wr_stat[i]  = wr && (ch_sel == 2'(i)) && (reg_sel == RegStat);
    assign match[i]    = (cnt_q[i] == thres_q[i]);
    assign evt[i]      = en_q[i] & tick_q[i] & match[i];
  end

  always_comb begin
    en_d    = en_q;
    mode_d  = mode_q;
    irqen_d = irqen_q;
    done_d  = done_q;
    pend_d  = pend_q;
    tick_d  = tick_q;
    prsc_d  = prsc_q;
    thres_d = thres_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      tick_d[i] = clkgen_i[prsc_q[i]];
      if (wr_ctrl[i]) begin
        en_d[i]    = data_i[0];
        prsc_d[i]  = data_i[3:1];
        mode_d[i]  = data_i[4];
        irqen_d[i] = data_i[5];
      end
      if (wr_thres[i]) thres_d[i] = data_i[CNT_W-1:0];
      // A bus write to COUNT always beats the counting logic.
      if (wr_cnt[i]) begin
        cnt_d[i] = data_i[CNT_W-1:0];
      end else if (en_q[i] && tick_q[i] && !match[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (evt[i] && mode_q[i]) begin
        cnt_d[i] = '0;
      end
      if (wr_cnt[i] || (wr_ctrl[i] && !data_i[0])) begin
        done_d[i] = 1'b0;
      end else if (evt[i] && !mode_q[i]) begin
        done_d[i] = 1'b1;
      end
      // A new event wins over a simultaneous write-1-clear.
      if (evt[i]) begin
        pend_d[i] = 1'b1;
      end else if (wr_stat[i] && data_i[0]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == 2'(i)) begin
        case (reg_sel)
          RegCtrl:  rdata = {25'd0, done_q[i], irqen_q[i], mode_q[i], prsc_q[i], en_q[i]};
          RegThres: rdata = 32'(thres_q[i]);
          RegCount: rdata = 32'(cnt_q[i]);
          default:  rdata = {31'd0, pend_q[i]};
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      en_q    <= '0;
      mode_q  <= '0;
      irqen_q <= '0;
      done_q  <= '0;
      pend_q  <= '0;
      tick_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        prsc_q[i]  <= '0;
        thres_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
      data_q <= '0;
      ack_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      en_q    <= en_d;
      mode_q  <= mode_d;
      irqen_q <= irqen_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      tick_q  <= tick_d;
      prsc_q  <= prsc_d;
      thres_q <= thres_d;
      cnt_q   <= cnt_d;
      data_q  <= rd ? rdata : 32'd0;
      ack_q   <= rd | wr;
      irq_q   <= |(pend_q & irqen_q);
    end
  end

  assign data_o      = data_q;
  assign ack_o       = ack_q;
  assign irq_o       = irq_q;
  assign clkgen_en_o = |en_q;

endmodule

// File: tb/tb_cellrv32_gptmr_mc.sv
// Directed self-checking bench: a default timer instance plus a narrow two-channel instance.
module tb_cellrv32_gptmr_mc;

  localparam logic [31:0] ABASE = 32'hFFFFF000;
  localparam logic [31:0] BBASE = 32'h00001000;

  logic        clk, rstn;
  logic [7:0]  clkgen;
  logic [31:0] a_addr, a_wdata, a_rdata, b_addr, b_wdata, b_rdata;
  logic        a_rden, a_wren, a_ack, a_cg_en, a_irq;
  logic        b_rden, b_wren, b_ack, b_cg_en, b_irq;
  int          n_cmp, n_bad;

  cellrv32_gptmr_mc #(.NUM_CH(4), .CNT_W(32), .BASE_ADDR(ABASE)) u_dut_a (
    .clk_i(clk), .rstn_i(rstn), .addr_i(a_addr), .rden_i(a_rden), .wren_i(a_wren),
    .data_i(a_wdata), .data_o(a_rdata), .ack_o(a_ack), .clkgen_en_o(a_cg_en),
    .clkgen_i(clkgen), .irq_o(a_irq)
  );

  cellrv32_gptmr_mc #(.NUM_CH(2), .CNT_W(8), .BASE_ADDR(BBASE)) u_dut_b (
    .clk_i(clk), .rstn_i(rstn), .addr_i(b_addr), .rden_i(b_rden), .wren_i(b_wren),
    .data_i(b_wdata), .data_o(b_rdata), .ack_o(b_ack), .clkgen_en_o(b_cg_en),
    .clkgen_i(clkgen), .irq_o(b_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  // Bus tasks are entered and left 1 time unit after a rising edge.
  task automatic bus_write(input bit b, input logic [31:0] a, input logic [31:0] d);
    if (b) begin b_addr = a; b_wdata = d; b_wren = 1'b1; end
    else   begin a_addr = a; a_wdata = d; a_wren = 1'b1; end
    @(posedge clk); #1;
    a_wren = 1'b0;
    b_wren = 1'b0;
  endtask

  task automatic bus_read(input bit b, input logic [31:0] a, output logic [31:0] d,
                          output logic ak);
    if (b) begin b_addr = a; b_rden = 1'b1; end
    else   begin a_addr = a; a_rden = 1'b1; end
    @(posedge clk); #1;
    a_rden = 1'b0;
    b_rden = 1'b0;
    d  = b ? b_rdata : a_rdata;
    ak = b ? b_ack : a_ack;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        ak;
    n_cmp++;
    if ({a_rdata, a_ack, a_irq, a_cg_en} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h required 0", {a_rdata, a_ack, a_irq, a_cg_en});
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    for (int r = 0; r < 4; r++) begin
      bus_read(1'b0, ABASE + 32'(4 * r), d, ak);
      n_cmp++;
      if (d !== 32'd0 || ak !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_reg%0d: got %h ack %b required 0 ack 1", r, d, ak);
      end
    end
  endtask

  task automatic test_continuous();
    logic [31:0] d;
    logic        ak;
    int          exp_cnt [6] = '{0, 1, 2, 3, 0, 1};
    logic        exp_irq [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bus_write(1'b0, ABASE + 32'h4, 32'd3);
    bus_write(1'b0, ABASE + 32'h0, 32'h31);
    for (int k = 0; k < 6; k++) begin
      bus_read(1'b0, ABASE + 32'h8, d, ak);
      n_cmp++;
      if (d !== 32'(exp_cnt[k])) begin
        n_bad++;
        $display("FAIL cont_count[%0d]: got %h required %h", k, d, exp_cnt[k]);
      end
      n_cmp++;
      if (a_irq !== exp_irq[k]) begin
        n_bad++;
        $display("FAIL cont_irq[%0d]: got %b required %b", k, a_irq, exp_irq[k]);
      end
    end
    bus_read(1'b0, ABASE + 32'hC, d, ak);
    n_cmp++;
    if (d !== 32'd1) begin
      n_bad++;
      $display("FAIL cont_pend: got %h required 1", d);
    end
    n_cmp++;
    if (a_cg_en !== 1'b1) begin
      n_bad++;
      $display("FAIL cont_clkgen_en: got %b required 1", a_cg_en);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    logic        ak;
    bus_read(1'b0, ABASE + 32'h0, d, ak);
    n_cmp++;
    if (d !== 32'h31 || ak !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_pre_ctrl: got %h ack %b required 31 ack 1", d, ak);
    end
    a_addr = ABASE;
    a_rden = 1'b1;
    rstn   = 1'b0;
    #1;
    n_cmp++;
    if ({a_rdata, a_ack, a_irq, a_cg_en} !== 35'd0) begin
      n_bad++;
      $display("FAIL arst_immediate: got %h required 0", {a_rdata, a_ack, a_irq, a_cg_en});
    end
    @(posedge clk); #1;
    a_rden = 1'b0;
    n_cmp++;
    if (a_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_pending_ack: got %b required 0", a_ack);
    end
    rstn = 1'b1;
    bus_read(1'b0, ABASE + 32'h8, d, ak);
    n_cmp++;
    if (d !== 32'd0) begin
      n_bad++;
      $display("FAIL arst_count: got %h required 0", d);
    end
    bus_read(1'b0, ABASE + 32'h0, d, ak);
    n_cmp++;
    if (d !== 32'd0 || a_irq !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_ctrl_irq: got %h irq %b required 0 irq 0", d, a_irq);
    end
  endtask

  task automatic test_single_shot();
    logic [31:0] d;
    logic        ak;
    bus_write(1'b0, ABASE + 32'h14, 32'd2);
    bus_write(1'b0, ABASE + 32'h10, 32'h21);
    repeat (5) @(posedge clk);
    #1;
    bus_read(1'b0, ABASE + 32'h18, d, ak);
    n_cmp++;
    if (d !== 32'd2) begin n_bad++; $display("FAIL ss_count_hold: got %h required 2", d); end
    bus_read(1'b0, ABASE + 32'h10, d, ak);
    n_cmp++;
    if (d !== 32'h61) begin n_bad++; $display("FAIL ss_done: got %h required 61", d); end
    bus_read(1'b0, ABASE + 32'h1C, d, ak);
    n_cmp++;
    if (d !== 32'd1) begin n_bad++; $display("FAIL ss_pend: got %h required 1", d); end
    bus_write(1'b0, ABASE + 32'h10, 32'h0);
    bus_read(1'b0, ABASE + 32'h10, d, ak);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL ss_done_clr: got %h required 0", d); end
    bus_read(1'b0, ABASE + 32'h18, d, ak);
    n_cmp++;
    if (d !== 32'd2) begin n_bad++; $display("FAIL ss_count_kept: got %h required 2", d); end
    bus_write(1'b0, ABASE + 32'h1C, 32'd1);
    @(posedge clk); #1;
    n_cmp++;
    if (a_irq !== 1'b0) begin n_bad++; $display("FAIL ss_irq_clr: got %b required 0", a_irq); end
  endtask

  task automatic test_stat_clear();
    logic [31:0] d;
    logic        ak;
    bus_write(1'b0, ABASE + 32'h24, 32'd0);
    bus_write(1'b0, ABASE + 32'h20, 32'h33);
    bus_read(1'b0, ABASE + 32'h2C, d, ak);
    n_cmp++;
    if (d !== 32'd0) begin n_bad++; $display("FAIL stat_no_tick: got %h required 0", d); end
    clkgen[1] = 1'b1;
    @(posedge clk); #1;
    clkgen[1] = 1'b0;
    @(posedge clk); #1;
    bus_read(1'b0, ABASE + 32'h2C, d, ak);
    n_cmp++;
    if (d !== 32'd1) begin n_bad++; $display("FAIL stat_first_evt: got %h required 1", d); end
    clkgen[1] = 1'b1;
    @(posedge clk); #1;
    clkgen[1] = 1'b0;
    bus_write(1'b0, ABASE + 32'h2C, 32'd1);
    bus_read(1'b0, ABASE + 32'h2C, d, ak);
    n_cmp++;
    if (d !== 32'd1) begin n_bad++; $display("FAIL stat_set_wins: got %h required 1", d); end
    n_cmp++;
    if (a_irq !== 1'b1) begin n_bad++; $display("FAIL stat_irq_on: got %b required 1", a_irq); end
    bus_write(1'b0, ABASE + 32'h2C, 32'd1);
    n_cmp++;
    if (a_irq !== 1'b1) begin n_bad++; $display("FAIL stat_irq_lag: got %b required 1", a_irq); end
    @(posedge clk); #1;
    n_cmp++;
    if (a_irq !== 1'b0) begin n_bad++; $display("FAIL stat_irq_off: got %b required 0", a_irq); end
    bus_read(1'b0, ABASE + 32'h2C, d, ak);
    n_cmp++;
    if (d !== 32'd0) begin n_bad++; $display("FAIL stat_cleared: got %h required 0", d); end
    bus_write(1'b0, ABASE + 32'h20, 32'h0);
  endtask

  task automatic test_wrap_narrow();
    logic [31:0] d;
    logic        ak;
    logic [31:0] exp_cnt [10] = '{32'hFE, 32'hFF, 32'h00, 32'h01, 32'h02,
                                  32'h03, 32'h04, 32'h05, 32'h00, 32'h01};
    bus_write(1'b1, BBASE + 32'h4, 32'h12345605);
    bus_write(1'b1, BBASE + 32'h0, 32'h11);
    bus_read(1'b1, BBASE + 32'h4, d, ak);
    n_cmp++;
    if (d !== 32'h05) begin n_bad++; $display("FAIL wrap_thres_trunc: got %h required 05", d); end
    bus_write(1'b1, BBASE + 32'h8, 32'hABCDEFFE);
    for (int k = 0; k < 10; k++) begin
      bus_read(1'b1, BBASE + 32'h8, d, ak);
      n_cmp++;
      if (d !== exp_cnt[k]) begin
        n_bad++;
        $display("FAIL wrap_count[%0d]: got %h required %h", k, d, exp_cnt[k]);
      end
    end
    bus_read(1'b1, BBASE + 32'hC, d, ak);
    n_cmp++;
    if (d !== 32'd1) begin n_bad++; $display("FAIL wrap_pend: got %h required 1", d); end
    n_cmp++;
    if (b_irq !== 1'b0) begin n_bad++; $display("FAIL wrap_irq_masked: got %b required 0", b_irq); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    logic        ak;
    bus_write(1'b1, BBASE + 32'h0, 32'h0);
    bus_write(1'b1, BBASE + 32'h30, 32'h31);
    n_cmp++;
    if (b_ack !== 1'b1) begin n_bad++; $display("FAIL unmap_wr_ack: got %b required 1", b_ack); end
    n_cmp++;
    if (b_cg_en !== 1'b0) begin n_bad++; $display("FAIL unmap_no_en: got %b required 0", b_cg_en); end
    bus_read(1'b1, BBASE + 32'h30, d, ak);
    n_cmp++;
    if (d !== 32'd0 || ak !== 1'b1) begin
      n_bad++;
      $display("FAIL unmap_rd: got %h ack %b required 0 ack 1", d, ak);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (b_rdata !== 32'd0 || b_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_bus: got %h ack %b required 0 ack 0", b_rdata, b_ack);
    end
    bus_write(1'b0, ABASE + 32'h30, 32'hFFFFFFFF);
    bus_read(1'b0, ABASE + 32'h30, d, ak);
    n_cmp++;
    if (d !== 32'h3F) begin n_bad++; $display("FAIL ctrl_unused_bits: got %h required 3f", d); end
    bus_write(1'b0, ABASE + 32'h30, 32'h0);
    bus_write(1'b0, 32'h00002000, 32'h1);
    n_cmp++;
    if (a_ack !== 1'b0) begin n_bad++; $display("FAIL nodecode_ack: got %b required 0", a_ack); end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rstn    = 1'b0;
    clkgen  = 8'h01;
    a_addr  = '0; a_wdata = '0; a_rden = 1'b0; a_wren = 1'b0;
    b_addr  = '0; b_wdata = '0; b_rden = 1'b0; b_wren = 1'b0;
    #1;
    test_reset();
    test_continuous();
    test_async_reset();
    test_single_shot();
    test_stat_clear();
    test_wrap_narrow();
    test_unmapped();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
